// File: rtl/mcc_pkg.sv
// mcc_pkg: shared definitions for the multi-cycle CPU peripherals.
//   - UART register word offsets (mem_addr[3:2])
//   - UART STATUS bit positions
//   - UART transmitter state encoding
//   - baud_reload(): converts a divisor into the down-counter reload value
package mcc_pkg;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_DIV    = 2'd2;

    localparam int unsigned UART_STAT_BUSY    = 0;
    localparam int unsigned UART_STAT_FULL    = 1;
    localparam int unsigned UART_STAT_EMPTY   = 2;
    localparam int unsigned UART_STAT_OVF     = 3;
    localparam int unsigned UART_STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    // Bit period is max(div, 1) cycles; the baud counter counts down to zero.
    function automatic logic [15:0] baud_reload(input logic [15:0] div);
        return (div > 16'd1) ? (div - 16'd1) : 16'd0;
    endfunction

endpackage

// File: rtl/mcc_uart_tx_if.sv
// mcc_uart_tx_if: CPU data-port slice seen by the UART transmitter.
//   sel     - address-decoder hit for the 16-byte window
//   addr    - word offset (mem_addr[3:2])
//   wdata   - write data (mem_wdata)
//   wenable - byte strobes (mem_wenable)
//   rdata   - combinational read data, 0 when !sel
// master: CPU / bus side.  slave: the UART.
interface mcc_uart_tx_if;

    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wenable;
    logic [31:0] rdata;

    modport master (
        output sel,
        output addr,
        output wdata,
        output wenable,
        input  rdata
    );

    modport slave (
        input  sel,
        input  addr,
        input  wdata,
        input  wenable,
        output rdata
    );

endinterface

// File: rtl/mcc_sync_fifo.sv
// mcc_sync_fifo: single-clock FIFO with pointer-plus-wrap-bit full/empty detection.
//   clk, rst - clock, synchronous active-high reset (flushes the FIFO)
//   push     - write wdata; accepted when not full, or when a pop happens the same cycle
//   pop      - drop the head entry; ignored when empty
//   wdata    - data to push
//   head     - current head entry (valid when !empty)
//   full     - DEPTH entries held
//   empty    - no entries held
//   count    - number of entries held (0..DEPTH)
module mcc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: the writer is a full lap ahead.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written (head is read before the edge).
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mcc_uart_tx.sv
// mcc_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset; aborts any frame and flushes the FIFO
//   bus  - CPU data port (slave): sel/addr/wdata/wenable in, combinational rdata out
//   txd  - serial output, idle high
//   irq  - registered, high while the FIFO is empty and the transmitter idle
// Registers: 0 DATA (W push), 1 STATUS (R, W1 bit3 clears overflow), 2 DIV (R/W [15:0]).
module mcc_uart_tx
    import mcc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic         clk,
    input  logic         rst,
    mcc_uart_tx_if.slave bus,
    output logic         txd,
    output logic         irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        irq_q;
    logic [15:0] div_q;
    logic        ovf_q;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_ext;
    logic [3:0]    count_sat;
    logic          bit_done;
    logic          wr_div_lo, wr_div_hi, clr_ovf;
    logic [31:0]   status;
    logic [31:0]   rdata;
    logic          unused_bus;

    // Register write decode
    assign fifo_push = bus.sel && (bus.addr == UART_REG_DATA) && bus.wenable[0];
    assign wr_div_lo = bus.sel && (bus.addr == UART_REG_DIV) && bus.wenable[0];
    assign wr_div_hi = bus.sel && (bus.addr == UART_REG_DIV) && bus.wenable[1];
    assign clr_ovf   = bus.sel && (bus.addr == UART_REG_STATUS) && bus.wenable[0] &&
                       bus.wdata[UART_STAT_OVF];
    assign unused_bus = ^{bus.wdata[31:16], bus.wenable[3:2]};

    mcc_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.wdata[7:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // TX FSM next-state and pop generation
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        bit_done = (baud_q == 16'd0);

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = baud_reload(div_q);
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    bit_d   = 3'd0;
                    baud_d  = baud_reload(div_q);
                    state_d = StData;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    baud_d  = baud_reload(div_q);
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StStop: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        baud_d   = baud_reload(div_q);
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // txd is registered from the next state so it is glitch-free.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            irq_q   <= 1'b1;
            div_q   <= DIV_RESET;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            irq_q   <= fifo_empty && (state_q == StIdle);
            if (wr_div_lo) begin
                div_q[7:0] <= bus.wdata[7:0];
            end
            if (wr_div_hi) begin
                div_q[15:8] <= bus.wdata[15:8];
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // STATUS assembly; count saturates at 15 for deep FIFOs.
    assign count_ext = 32'(fifo_count);
    assign count_sat = (count_ext > 32'd15) ? 4'hf : count_ext[3:0];

    always_comb begin
        status = '0;
        status[UART_STAT_BUSY]             = (state_q != StIdle);
        status[UART_STAT_FULL]             = fifo_full;
        status[UART_STAT_EMPTY]            = fifo_empty;
        status[UART_STAT_OVF]              = ovf_q;
        status[UART_STAT_CNT_LSB +: 4]     = count_sat;
    end

    // Combinational read: the CPU samples rdata in the address cycle.
    always_comb begin
        rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                UART_REG_STATUS: rdata = status;
                UART_REG_DIV:    rdata = {16'h0000, div_q};
                default:         rdata = '0;
            endcase
        end
    end

    assign bus.rdata = rdata;
    assign txd       = txd_q;
    assign irq       = irq_q;

endmodule
